// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl
//   Sequencer in front of the 32-entry register file. Decode read requests and
//   write-back results share the single register-file port: at most one READ or
//   one WRITE per cycle. Write-back results are parked in a small FIFO and
//   drained in program order. Reads are forwarded from pending FIFO entries, so
//   software observes program-order register values.
//
// Ports
//   CLK, RST             clock, synchronous active-low reset
//   rd_req/rd_addr1/2    operand read request from decode
//   rd_ack               read accepted this cycle (combinational)
//   rd_valid/rd_data1/2  operand results, one cycle after rd_ack
//   wb_valid/addr/data   write-back offer
//   wb_ready             write buffer accepts (combinational)
//   flush_req/done       drain request (level) and registered completion
//   RF_*                 register-file control, address and data pins
module rf_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ready,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  RF_READ,
  output logic                  RF_WRITE,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {OP_IDLE, OP_RD, OP_WR} op_t;

  // Write buffer storage. Every entry is compared against the read addresses in
  // parallel, so the arrays are read asynchronously.
  logic [ADDR_WIDTH-1:0] fifo_addr_reg [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;

  logic                  rd_valid_reg;
  logic [DATA_WIDTH-1:0] rd_data1_reg;
  logic [DATA_WIDTH-1:0] rd_data2_reg;
  logic                  flush_done_reg;

  op_t  op;
  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // Priority: a full buffer must drain, then flush drain, then reads, then
  // opportunistic drain. Everything is held off while in reset.
  always_comb begin
    op = OP_IDLE;
    if (RST) begin
      if (full)                      op = OP_WR;
      else if (flush_req && !empty)  op = OP_WR;
      else if (rd_req && !flush_req) op = OP_RD;
      else if (!empty)               op = OP_WR;
    end
  end

  assign wb_ready = RST & ~full & ~flush_req;
  // Writes to r0 are acknowledged but dropped: r0 is hard-wired to zero.
  assign push     = wb_valid & wb_ready & (wb_addr != '0);
  assign pop      = (op == OP_WR);
  assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

  // Oldest-to-youngest view of the buffer: slot gi holds the gi-th oldest entry.
  logic [ADDR_WIDTH-1:0] ord_addr [DEPTH];
  logic [DATA_WIDTH-1:0] ord_data [DEPTH];
  logic [DEPTH-1:0]      hit1;
  logic [DEPTH-1:0]      hit2;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ord
      logic [PTR_W-1:0] idx;
      logic             live;
      assign idx          = rd_ptr_reg + PTR_W'(gi);
      assign live         = (CNT_W'(gi) < count_reg);
      assign ord_addr[gi] = fifo_addr_reg[idx];
      assign ord_data[gi] = fifo_data_reg[idx];
      assign hit1[gi]     = live && (ord_addr[gi] == rd_addr1);
      assign hit2[gi]     = live && (ord_addr[gi] == rd_addr2);
    end
  endgenerate

  // Later (younger) matches override earlier ones. Only start-of-cycle buffer
  // contents are visible, so a same-cycle push does not forward.
  logic [DATA_WIDTH-1:0] fwd1;
  logic [DATA_WIDTH-1:0] fwd2;

  always_comb begin
    fwd1 = RF_DATA_R1;
    fwd2 = RF_DATA_R2;
    for (int k = 0; k < DEPTH; k++) begin
      if (hit1[k]) fwd1 = ord_data[k];
      if (hit2[k]) fwd2 = ord_data[k];
    end
    if (rd_addr1 == '0) fwd1 = '0;
    if (rd_addr2 == '0) fwd2 = '0;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr_reg[wr_ptr_reg] <= wb_addr;
      fifo_data_reg[wr_ptr_reg] <= wb_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      rd_valid_reg   <= 1'b0;
      rd_data1_reg   <= '0;
      rd_data2_reg   <= '0;
      flush_done_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg    <= count_next;
      rd_valid_reg <= (op == OP_RD);
      if (op == OP_RD) begin
        rd_data1_reg <= fwd1;
        rd_data2_reg <= fwd2;
      end
      flush_done_reg <= flush_req && (count_next == '0);
    end
  end

  assign rd_ack     = (op == OP_RD);
  assign rd_valid   = rd_valid_reg;
  assign rd_data1   = rd_data1_reg;
  assign rd_data2   = rd_data2_reg;
  assign flush_done = flush_done_reg;

  assign RF_READ    = (op == OP_RD);
  assign RF_WRITE   = (op == OP_WR);
  assign RF_ADDR_R1 = (op == OP_RD) ? rd_addr1 : '0;
  assign RF_ADDR_R2 = (op == OP_RD) ? rd_addr2 : '0;
  assign RF_ADDR_W  = (op == OP_WR) ? fifo_addr_reg[rd_ptr_reg] : '0;
  assign RF_DATA_W  = (op == OP_WR) ? fifo_data_reg[rd_ptr_reg] : '0;

endmodule

// File: doc/rf_access_ctrl.md
Name: rf_access_ctrl

Overview:
- Access sequencer placed in front of the 32x32 register file. It is the only block that drives the register file's READ/WRITE/address/data pins.
- Takes operand-read requests from decode and result writes from write-back.
- Buffers writes in a small FIFO, so the register file sees at most one operation per cycle (READ xor WRITE).
- Forwards pending buffered writes to reads, so software sees program-order register semantics.

Parameters:
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width (32 registers).
- DEPTH, 4, write-buffer entries; power of two, >=2.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous reset, active-low.
- rd_req  in  1  decode requests an operand read.
- rd_addr1  in  ADDR_WIDTH  operand 1 register.
- rd_addr2  in  ADDR_WIDTH  operand 2 register.
- rd_ack  out  1  read accepted this cycle (combinational).
- rd_valid  out  1  rd_data1/2 valid (registered, one-cycle pulse).
- rd_data1  out  DATA_WIDTH  operand 1 result.
- rd_data2  out  DATA_WIDTH  operand 2 result.
- wb_valid  in  1  write-back offers a write.
- wb_addr  in  ADDR_WIDTH  destination register.
- wb_data  in  DATA_WIDTH  write data.
- wb_ready  out  1  write buffer can accept (combinational).
- flush_req  in  1  level; drain all buffered writes.
- flush_done  out  1  registered; buffer empty while flush_req high.
- RF_READ  out  1  register file READ.
- RF_WRITE  out  1  register file WRITE.
- RF_ADDR_R1  out  ADDR_WIDTH  register file read address 1.
- RF_ADDR_R2  out  ADDR_WIDTH  register file read address 2.
- RF_ADDR_W  out  ADDR_WIDTH  register file write address.
- RF_DATA_W  out  DATA_WIDTH  register file write data.
- RF_DATA_R1  in  DATA_WIDTH  register file read data 1.
- RF_DATA_R2  in  DATA_WIDTH  register file read data 2.

Behaviour:
- Reset (RST=0 sampled at posedge):
  - FIFO pointers and count cleared.
  - rd_valid=0, rd_data1/2=0, flush_done=0.
  - While RST=0, RF_READ, RF_WRITE, rd_ack and wb_ready are forced 0 combinationally.
  - Reset mid-operation discards all buffered writes; they never reach the register file.
- Per-cycle operation select (combinational from registered state plus inputs). Exactly one of OP_IDLE, OP_RD, OP_WR, chosen by first matching rule:
  1. FIFO full -> OP_WR.
  2. flush_req=1 and FIFO non-empty -> OP_WR.
  3. rd_req=1 and flush_req=0 -> OP_RD.
  4. FIFO non-empty -> OP_WR.
  5. Otherwise OP_IDLE.
- OP_RD:
  - RF_READ=1, RF_WRITE=0, rd_ack=1.
  - RF_ADDR_R1/R2 = rd_addr1/2.
  - At posedge: rd_data1/2 <= forwarded value, rd_valid <= 1.
  - Latency is exactly one cycle from ack to rd_valid.
- OP_WR:
  - RF_WRITE=1, RF_READ=0.
  - RF_ADDR_W/RF_DATA_W = oldest FIFO entry.
  - Entry is popped at posedge.
- OP_IDLE: RF_READ=RF_WRITE=0.
- rd_valid is 0 in every cycle not following an OP_RD. RF_DATA_R* is sampled only in OP_RD, because the register file drives Z otherwise.
- Forwarding, applied per operand independently:
  - Address 0 returns 0.
  - Otherwise, if one or more FIFO entries match the address, the youngest matching entry's data is used.
  - Otherwise RF_DATA_Rn is used.
  - The match uses FIFO contents at the start of the cycle. A write pushed in the same cycle is not visible (read-before-write ordering).
- Write accept:
  - wb_ready = RST & !full & !flush_req.
  - Push when wb_valid & wb_ready.
  - wb_addr=0 is accepted but not enqueued (discarded).
  - Push and pop in the same cycle are allowed: count unchanged, pointers both advance.
  - A push when the FIFO is full is impossible because wb_ready=0.
- Writes reach the register file in FIFO (program) order. The FIFO never reorders or merges entries.
- Flush:
  - While flush_req=1, reads are not acked and pushes are refused.
  - flush_done <= (flush_req & FIFO empty after this cycle's pop), so flush_done asserts the cycle after the last drain.
  - flush_done deasserts the cycle after flush_req drops.
- Invariant: RF_READ & RF_WRITE is never 1.

Test Plan:
- Reset, then 2 idle cycles -> all outputs 0; RF_READ=RF_WRITE=0; wb_ready=1 after reset release.
- Push wb (addr 5, 0xDEADBEEF) with no reads -> next cycle RF_WRITE=1, RF_ADDR_W=5, RF_DATA_W=0xDEADBEEF; then idle. A later read of r5/r0 -> rd_data1=0xDEADBEEF, rd_data2=0.
- Push r7=0x11, then r7=0x22; hold rd_req (r7, r7) continuously -> reads win until FIFO fills. Forwarded value is 0x22 (youngest). RF_READ never overlaps RF_WRITE.
- Push 4 writes back-to-back with rd_req held high -> full on the 4th push, wb_ready=0. Next cycle OP_WR beats rd_req (rd_ack=0). Push and pop in the same cycle keep count stable.
- Same-cycle push of r3=0x55 and read of r3, with register file holding 0x00 -> rd_data1=0x00. A read the following cycle -> 0x55.
- 3 buffered writes, then flush_req=1 -> 3 consecutive RF_WRITE cycles, flush_done=1 on the 4th cycle. rd_ack=0 and wb_ready=0 throughout. Assert RST=0 with entries pending -> no RF_WRITE afterwards; FIFO empty.
